// File: rtl/mux7_rr_arbiter.sv
// mux7_rr_arbiter
//   Round-robin arbiter sharing a 7:1 mux among seven requesters. One grant
//   at a time. Each tenure is bounded to MAX_HOLD cycles when others wait.
//
// Parameters
//   MAX_HOLD : max consecutive granted cycles under contention (1..15)
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   req   : level-sensitive request vector, bit i = requester i
//   grant : registered one-hot grant, zero when idle
//   sel   : registered binary index of the grantee, 3'b111 when idle
//   busy  : registered, high whenever grant is nonzero
module mux7_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] req,
    output logic [6:0] grant,
    output logic [2:0] sel,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [6:0] grant_q, grant_d;
    logic [2:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;
    logic       new_grant;

    // Increment modulo 7 (6 wraps to 0).
    function automatic logic [2:0] inc7(input logic [2:0] v);
        return (v == 3'd6) ? 3'd0 : v + 3'd1;
    endfunction

    // First requester found scanning start, start+1, ... with wrap at 7.
    // Only called with a nonzero request vector.
    function automatic logic [2:0] pick(input logic [6:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        idx   = start;
        res   = start;
        found = 1'b0;
        for (int unsigned k = 0; k < 7; k++) begin
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
            idx = inc7(idx);
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        new_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = GRANT;
                    owner_d   = pick(req, ptr_q);
                    cnt_d     = '0;
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    if (|req) begin
                        owner_d   = pick(req, inc7(owner_q));
                        cnt_d     = '0;
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Scanning from owner+1 lands back on the owner when it is
                    // the sole requester, which gives the re-grant for free.
                    owner_d   = pick(req, inc7(owner_q));
                    cnt_d     = '0;
                    new_grant = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (new_grant) begin
            ptr_d = inc7(owner_d);
        end

        // Outputs decoded from next state so they register together.
        if (state_d == GRANT) begin
            grant_d = 7'(1) << owner_d;
            sel_d   = owner_d;
            busy_d  = 1'b1;
        end else begin
            grant_d = '0;
            sel_d   = '1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            sel_q   <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// Testbench for mux7_rr_arbiter: directed vector table, full-contention
// sequence, and randomized traffic against a reference model, run on a
// MAX_HOLD=4 instance and a MAX_HOLD=1 instance sharing the same inputs.
module tb_mux7_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] req;
    logic [6:0] grant4, grant1;
    logic [2:0] sel4, sel1;
    logic       busy4, busy1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux7_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .reset(reset), .req(req),
        .grant(grant4), .sel(sel4), .busy(busy4)
    );

    mux7_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req),
        .grant(grant1), .sel(sel1), .busy(busy1)
    );

    // Reference model: who owns the mux, how many cycles of its tenure have
    // elapsed (1-based), and where the next idle scan starts.
    int hold_lim [2] = '{4, 1};
    int m_busy   [2];
    int m_owner  [2];
    int m_ptr    [2];
    int m_ten    [2];

    function automatic int mpick(logic [6:0] r, int start);
        for (int k = 0; k < 7; k++) begin
            if (r[(start + k) % 7]) return (start + k) % 7;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rst, input logic [6:0] r);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_busy[m] = 0; m_owner[m] = 0; m_ptr[m] = 0; m_ten[m] = 0;
            end else if (m_busy[m] == 0) begin
                if (r != 0) begin
                    m_owner[m] = mpick(r, m_ptr[m]);
                    m_busy[m]  = 1;
                    m_ten[m]   = 1;
                    m_ptr[m]   = (m_owner[m] + 1) % 7;
                end
            end else if (!r[m_owner[m]] || m_ten[m] == hold_lim[m]) begin
                if (r == 0) begin
                    m_busy[m] = 0;
                end else begin
                    m_owner[m] = mpick(r, (m_owner[m] + 1) % 7);
                    m_ten[m]   = 1;
                    m_ptr[m]   = (m_owner[m] + 1) % 7;
                end
            end else begin
                m_ten[m] = m_ten[m] + 1;
            end
        end
    endtask

    function automatic logic [10:0] model_out(int m);
        if (m_busy[m] != 0) return {7'(1) << m_owner[m], 3'(m_owner[m]), 1'b1};
        return {7'b0, 3'b111, 1'b0};
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got grant=%b sel=%0d busy=%b, want grant=%b sel=%0d busy=%b",
                     name, idx, act[10:4], act[3:1], act[0], exp[10:4], exp[3:1], exp[0]);
        end
    endtask

    // Drives the inputs through one rising edge, then advances the model.
    task automatic step(input logic rst, input logic [6:0] r);
        reset = rst;
        req   = r;
        @(posedge clk);
        model_edge(rst, r);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [6:0] req;
        logic [6:0] g;
        logic [2:0] s;
        logic       b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [6:0] r,
                       input logic [6:0] g, input logic [2:0] s, input logic b);
        vec_t v;
        v.rst = rst; v.req = r; v.g = g; v.s = s; v.b = b;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        @(negedge clk);

        // Reset with everyone requesting, then first grant goes to 0.
        add(1, 7'h7F, 7'h00, 3'd7, 0);
        add(1, 7'h7F, 7'h00, 3'd7, 0);
        add(0, 7'h7F, 7'h01, 3'd0, 1);
        // Single requester 2: held across several re-grants, then released.
        add(1, 7'h04, 7'h00, 3'd7, 0);
        for (int i = 0; i < 9; i++) add(0, 7'h04, 7'h04, 3'd2, 1);
        add(0, 7'h00, 7'h00, 3'd7, 0);
        // Early release: owner 2 drops at cnt=1, 3 takes a fresh full tenure.
        add(1, 7'b0101100, 7'h00, 3'd7, 0);
        add(0, 7'b0101100, 7'h04, 3'd2, 1);
        add(0, 7'b0101100, 7'h04, 3'd2, 1);
        add(0, 7'b0101000, 7'h08, 3'd3, 1);
        for (int i = 0; i < 3; i++) add(0, 7'b0101000, 7'h08, 3'd3, 1);
        add(0, 7'b0101000, 7'h20, 3'd5, 1);
        // Wrap-around: owner 6 drops, scan wraps to 0, then moves on to 5.
        add(1, 7'b1000000, 7'h00, 3'd7, 0);
        add(0, 7'b1000000, 7'h40, 3'd6, 1);
        add(0, 7'b1100001, 7'h40, 3'd6, 1);
        add(0, 7'b0100001, 7'h01, 3'd0, 1);
        for (int i = 0; i < 3; i++) add(0, 7'b0100001, 7'h01, 3'd0, 1);
        add(0, 7'b0100001, 7'h20, 3'd5, 1);
        // Reset mid-tenure (owner 4, cnt 2): pointer cleared, next is 0.
        add(1, 7'b0010000, 7'h00, 3'd7, 0);
        add(0, 7'b0010000, 7'h10, 3'd4, 1);
        add(0, 7'b0010000, 7'h10, 3'd4, 1);
        add(0, 7'b0010000, 7'h10, 3'd4, 1);
        add(1, 7'b0010001, 7'h00, 3'd7, 0);
        add(0, 7'b0010001, 7'h01, 3'd0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req);
            check("vec", i, {grant4, sel4, busy4}, {vecs[i].g, vecs[i].s, vecs[i].b});
        end

        // Full contention: 32 cycles, four per owner in order 0..6,0.
        step(1, 7'h7F);
        for (int k = 0; k < 32; k++) begin
            step(0, 7'h7F);
            check("contend", k, {grant4, sel4, busy4},
                  {7'(1) << ((k / 4) % 7), 3'((k / 4) % 7), 1'b1});
            check("contend_h1", k, {grant1, sel1, busy1},
                  {7'(1) << (k % 7), 3'(k % 7), 1'b1});
        end

        // Randomized traffic with occasional resets and idle gaps.
        for (int k = 0; k < 600; k++) begin
            logic       rst;
            logic [6:0] r;
            rst = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = 7'(1) << $urandom_range(0, 6);
                default: r = 7'($urandom);
            endcase
            step(rst, r);
            check("rand_h4", k, {grant4, sel4, busy4}, model_out(0));
            check("rand_h1", k, {grant1, sel1, busy1}, model_out(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux7_rr_arbiter.md
# mux7_rr_arbiter

Round-robin arbiter that shares the 7-to-1 selection path among seven requesters. It grants exactly one requester at a time and drives a 3-bit select that feeds the `func` input of the 7:1 mux directly. Every tenure has a bounded hold time, so no requester can starve the others. It sits between the request sources (switch/key logic or upstream blocks) and the mux datapath.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive granted cycles per tenure when another requester is waiting. Legal range 1..15.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 7: request vector; bit i is requester i. Level-sensitive, sampled every edge.
- `grant` out 7: one-hot grant, or all zeros when idle. Registered.
- `sel` out 3: binary index of the granted requester (3'b000..3'b110); 3'b111 when idle. Registered. The mux outputs 0 for 3'b111.
- `busy` out 1: high whenever `grant` is nonzero. Registered.

## Operation
- State: FSM {IDLE, GRANT}; 3-bit `owner`; 3-bit priority pointer `ptr` (0..6); 4-bit hold counter `cnt`.
- Reset values:
  - FSM = IDLE, `ptr` = 0, `owner` = 0, `cnt` = 0.
  - `grant` = 7'b0, `sel` = 3'b111, `busy` = 0.
- Arbitration function `pick(start)`: the first i with `req[i]` = 1, scanning start, start+1, …, 6, 0, …, start−1. Indices wrap modulo 7; the value 7 is never produced.
- IDLE:
  - If `req` = 0, stay in IDLE.
  - Otherwise go to GRANT with `owner` = pick(`ptr`), `cnt` = 0.
- GRANT, evaluated each edge:
  - **Release:** `req[owner]` = 0.
    - Other requests pending: new `owner` = pick(`owner`+1), `cnt` = 0, stay in GRANT.
    - No requests: go to IDLE.
  - **Timeout:** `cnt` = MAX_HOLD−1 and `req[owner]` = 1.
    - Any other bit of `req` set: new `owner` = pick(`owner`+1), `cnt` = 0.
    - Owner is the sole requester: re-grant the same owner, `cnt` = 0.
  - **Otherwise:** hold the owner and set `cnt` = `cnt`+1.
- `ptr` update: on every new grant or re-grant, `ptr` = (`owner`+1) mod 7, with 6 wrapping to 0.
- Outputs are decoded from the next-state `owner` and FSM and registered, so `grant`, `sel` and `busy` are always mutually consistent.
- Bits of `req` that change in the same cycle as a release or timeout are taken as sampled at that edge. No request is latched or remembered after it is deasserted.
- `cnt` saturates logically: it never exceeds MAX_HOLD−1.

## Timing
- Request-to-grant latency: 1 edge. If `req` rises before edge k while the arbiter is idle, `grant`/`sel` are valid after edge k.
- Handover has no bubble. When the owner drops its request before edge k and others are pending, the new owner is visible after edge k. `busy` stays high across the handover.
- Release with no pending requests: `busy` falls after the same edge.
- Tenure length with contention: exactly MAX_HOLD cycles. The owner holds from its first grant cycle through cycle MAX_HOLD, then the grant moves on.
- With all seven requesting continuously, the service order is 0,1,2,3,4,5,6,0,…, with each tenure lasting MAX_HOLD cycles.
- Reset asserted mid-tenure: all outputs return to their reset values after that edge, regardless of `req`. The first grant after reset is pick(0).
- MAX_HOLD = 1: the grant rotates every cycle under contention.

## Test plan
- Reset: hold `reset` = 1 for 2 edges with `req` = 7'h7F. Required: `grant` = 0, `sel` = 3'b111, `busy` = 0. One edge after release, `grant` = 7'b0000001 and `sel` = 0.
- Single requester: `req` = 7'b0000100 from idle. Required: after 1 edge, `grant` = 7'b0000100, `sel` = 3'b010, `busy` = 1. It is held indefinitely, re-granted every MAX_HOLD cycles. Drop `req` and `busy` = 0 after the next edge.
- Full contention, MAX_HOLD = 4, `req` = 7'h7F for 32 cycles. Required: `sel` sequence 0,0,0,0,1,1,1,1,…,6,6,6,6,0; no cycle with `grant` = 0.
- Early release: owner 2 with `req` = 7'b0101100; drop bit 2 at cnt = 1. Required: after the next edge, `sel` = 3 and the new tenure's `cnt` restarts at 0.
- Wrap-around: owner 6 with `req` = 7'b1100001; drop bit 6. Required: next `sel` = 0, not 5. Then, after its tenure, `sel` = 5.
- Reset mid-tenure: with owner 4 and cnt = 2, pulse `reset` for 1 edge while `req` = 7'b0010001. Required: idle outputs for one cycle, then `sel` = 0 (pointer cleared, not 5).
